// File: rtl/pe_stream_feeder_pkg.sv
// Shared types for the PE stream feeder: per-configuration fetch parameters
// and the feeder FSM state encoding.
package pe_stream_feeder_pkg;

  typedef struct packed {
    logic [3:0] Pch;
    logic [3:0] R;
    logic [3:0] Pm;
    logic [5:0] Tw;
    logic [3:0] U;
    logic       PixReuse;
  } FeedConf;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } feed_state_e;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/pe_feed_chan.sv
// One GLB-to-stream channel: linear address walker, single-cycle read tracking,
// credit-limited issue and a 2-entry output FIFO driving a rdy/ack stream.
module pe_feed_chan
  import pe_stream_feeder_pkg::*;
#(
  parameter int DATAWD = 16,
  parameter int ADDRWD = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [15:0]       i_load_cnt,
  input  logic [ADDRWD-1:0] i_load_base,
  input  logic              i_run,
  output logic              o_rd,
  output logic [ADDRWD-1:0] o_raddr,
  input  logic [DATAWD-1:0] i_rdata,
  output logic              o_rdy,
  input  logic              i_ack,
  output logic [DATAWD-1:0] o_data,
  output logic              o_drained
);

  logic [15:0]       remaining;
  logic [ADDRWD-1:0] addr;
  logic              pending;
  logic [DATAWD-1:0] mem [FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fill;
  logic              push;
  logic              pop;
  logic [2:0]        occ;

  assign o_raddr = addr;
  assign o_rdy   = (fill != '0);
  assign o_data  = mem[rd_ptr];

  // occ is the FIFO occupancy after this cycle, counting the in-flight read.
  always_comb begin
    pop       = o_rdy && i_ack;
    push      = pending;
    occ       = 3'(fill) + 3'(pending) - 3'(pop);
    o_rd      = i_run && (remaining != '0) && (occ < 3'(FIFO_DEPTH));
    o_drained = (remaining == '0) && (occ == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      remaining <= '0;
      addr      <= '0;
      pending   <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fill      <= '0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else if (i_clear) begin
      remaining <= '0;
      pending   <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fill      <= '0;
    end else begin
      pending <= o_rd;
      if (i_load) begin
        remaining <= i_load_cnt;
        addr      <= i_load_base;
      end else if (o_rd) begin
        remaining <= remaining - 16'd1;
        addr      <= addr + ADDRWD'(1);
      end
      if (push) begin
        mem[wr_ptr] <= i_rdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fill <= fill + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/pe_stream_feeder.sv
// Producer of the PE Input/Weight rdy/ack streams: sizes one configuration,
// then drives two independent GLB fetch channels until both are drained.
module pe_stream_feeder
  import pe_stream_feeder_pkg::*;
#(
  parameter int DATAWD = 16,
  parameter int ADDRWD = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  FeedConf           i_conf,
  input  logic [ADDRWD-1:0] i_in_base,
  input  logic [ADDRWD-1:0] i_wt_base,
  output logic              o_in_rd,
  output logic [ADDRWD-1:0] o_in_raddr,
  input  logic [DATAWD-1:0] i_in_rdata,
  output logic              o_wt_rd,
  output logic [ADDRWD-1:0] o_wt_raddr,
  input  logic [DATAWD-1:0] i_wt_rdata,
  output logic              Input_rdy,
  input  logic              Input_ack,
  output logic [DATAWD-1:0] o_Input_data,
  output logic              Weight_rdy,
  input  logic              Weight_ack,
  output logic [DATAWD-1:0] o_Weight_data,
  output logic              o_busy,
  output logic              o_done
);

  feed_state_e state, state_nxt;
  logic [9:0]  tw_u;
  logic [9:0]  row_tile;
  logic [15:0] in_cnt;
  logic [15:0] wt_cnt;
  logic        chan_load;
  logic        chan_run;
  logic        in_drained;
  logic        wt_drained;

  always_comb begin
    tw_u     = 10'(i_conf.Tw) * 10'(i_conf.U);
    row_tile = i_conf.PixReuse ? tw_u + 10'(i_conf.R) - 10'd1
                               : 10'(i_conf.Tw) * 10'(i_conf.R);
    in_cnt   = 16'(i_conf.Pch) * 16'(row_tile);
    wt_cnt   = 16'(i_conf.Pch) * 16'(i_conf.R) * 16'(i_conf.Pm);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Drained flags look one cycle ahead so DONE follows the final transfer directly.
  always_comb begin
    state_nxt = state;
    chan_load = 1'b0;
    chan_run  = 1'b0;
    unique case (state)
      ST_IDLE: if (i_start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        chan_load = 1'b1;
        state_nxt = ((in_cnt != '0) || (wt_cnt != '0)) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        chan_run = 1'b1;
        if (in_drained && wt_drained) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (i_abort) begin
      state_nxt = ST_IDLE;
      chan_load = 1'b0;
      chan_run  = 1'b0;
    end
  end

  assign o_busy = (state != ST_IDLE);
  assign o_done = (state == ST_DONE);

  pe_feed_chan #(.DATAWD(DATAWD), .ADDRWD(ADDRWD)) u_in_chan (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_abort),
    .i_load     (chan_load),
    .i_load_cnt (in_cnt),
    .i_load_base(i_in_base),
    .i_run      (chan_run),
    .o_rd       (o_in_rd),
    .o_raddr    (o_in_raddr),
    .i_rdata    (i_in_rdata),
    .o_rdy      (Input_rdy),
    .i_ack      (Input_ack),
    .o_data     (o_Input_data),
    .o_drained  (in_drained)
  );

  pe_feed_chan #(.DATAWD(DATAWD), .ADDRWD(ADDRWD)) u_wt_chan (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_abort),
    .i_load     (chan_load),
    .i_load_cnt (wt_cnt),
    .i_load_base(i_wt_base),
    .i_run      (chan_run),
    .o_rd       (o_wt_rd),
    .o_raddr    (o_wt_raddr),
    .i_rdata    (i_wt_rdata),
    .o_rdy      (Weight_rdy),
    .i_ack      (Weight_ack),
    .o_data     (o_Weight_data),
    .o_drained  (wt_drained)
  );

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Randomized bench for pe_stream_feeder: GLB memories, address/data scoreboard
// derived from the configuration arithmetic, and cycle-exact start/done timing.
module tb_pe_stream_feeder;
  import pe_stream_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  FeedConf     i_conf;
  logic [11:0] i_in_base;
  logic [11:0] i_wt_base;
  logic        o_in_rd;
  logic [11:0] o_in_raddr;
  logic [15:0] i_in_rdata;
  logic        o_wt_rd;
  logic [11:0] o_wt_raddr;
  logic [15:0] i_wt_rdata;
  logic        Input_rdy;
  logic        Input_ack;
  logic [15:0] o_Input_data;
  logic        Weight_rdy;
  logic        Weight_ack;
  logic [15:0] o_Weight_data;
  logic        o_busy;
  logic        o_done;

  logic [15:0] in_mem [4096];
  logic [15:0] wt_mem [4096];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_stream_feeder #(.DATAWD(16), .ADDRWD(12)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_conf       (i_conf),
    .i_in_base    (i_in_base),
    .i_wt_base    (i_wt_base),
    .o_in_rd      (o_in_rd),
    .o_in_raddr   (o_in_raddr),
    .i_in_rdata   (i_in_rdata),
    .o_wt_rd      (o_wt_rd),
    .o_wt_raddr   (o_wt_raddr),
    .i_wt_rdata   (i_wt_rdata),
    .Input_rdy    (Input_rdy),
    .Input_ack    (Input_ack),
    .o_Input_data (o_Input_data),
    .Weight_rdy   (Weight_rdy),
    .Weight_ack   (Weight_ack),
    .o_Weight_data(o_Weight_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // GLB read ports: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    i_in_rdata <= o_in_rd ? in_mem[o_in_raddr] : 16'($urandom);
    i_wt_rdata <= o_wt_rd ? wt_mem[o_wt_raddr] : 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic FeedConf mk_conf(input int pch, input int r, input int pm,
                                      input int tw, input int u, input bit pr);
    FeedConf c;
    c.Pch = 4'(pch); c.R = 4'(r); c.Pm = 4'(pm);
    c.Tw = 6'(tw); c.U = 4'(u); c.PixReuse = pr;
    return c;
  endfunction

  task automatic run_cfg(input FeedConf cf, input logic [11:0] ib, input logic [11:0] wb,
                         input int ack_pct, input int abort_after, input int rst_cyc,
                         input bit start_mid);
    int rt, in_n, wt_n, mx;
    int in_rd = 0, in_x = 0, wt_rd = 0, wt_x = 0;
    int done_exp, abort_cyc = -1;
    bit fin = 1'b0;
    bit seen_in_rd = 0, seen_wt_rd = 0, seen_in_rdy = 0, seen_wt_rdy = 0;
    bit p_in_hold = 0, p_wt_hold = 0;
    logic [15:0] p_in_data = '0, p_wt_data = '0;

    rt   = cf.PixReuse ? int'(cf.Tw) * int'(cf.U) + int'(cf.R) - 1 : int'(cf.Tw) * int'(cf.R);
    in_n = int'(cf.Pch) * rt;
    wt_n = int'(cf.Pch) * int'(cf.R) * int'(cf.Pm);
    mx   = (in_n > wt_n) ? in_n : wt_n;
    done_exp = (mx == 0) ? 2 : -1;

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      i_conf    = cf;
      i_in_base = ib;
      i_wt_base = wb;
      i_start   = (cyc == 0) || (start_mid && cyc == 6);
      i_abort   = (cyc == abort_cyc);
      Input_ack  = (cyc != abort_cyc) && (int'($urandom_range(99)) < ack_pct);
      Weight_ack = (cyc != abort_cyc) && (int'($urandom_range(99)) < ack_pct);
      if (cyc == rst_cyc) i_rst_n = 1'b0;
      #1;
      if (cyc == rst_cyc) begin
        check("rst_in_rdy", Input_rdy, 0);
        check("rst_wt_rdy", Weight_rdy, 0);
        check("rst_busy", o_busy, 0);
        check("rst_in_rd", o_in_rd, 0);
        fin = 1'b1;
      end else if (abort_cyc >= 0 && cyc > abort_cyc) begin
        check("abort_in_rdy", Input_rdy, 0);
        check("abort_wt_rdy", Weight_rdy, 0);
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_rd", o_in_rd | o_wt_rd, 0);
        if (cyc == abort_cyc + 2) fin = 1'b1;
      end else if (cyc != abort_cyc) begin
        check("busy", o_busy, cyc >= 1);
        check("done", o_done, cyc == done_exp);
        if (p_in_hold) begin
          check("in_rdy_hold", Input_rdy, 1);
          check("in_data_hold", o_Input_data, p_in_data);
        end
        if (p_wt_hold) begin
          check("wt_rdy_hold", Weight_rdy, 1);
          check("wt_data_hold", o_Weight_data, p_wt_data);
        end
        if (o_in_rd) begin
          if (!seen_in_rd) check("in_first_rd_cyc", cyc, 2);
          seen_in_rd = 1;
          check("in_rd_in_range", in_rd < in_n, 1);
          check("in_raddr", o_in_raddr, 32'((int'(ib) + in_rd) % 4096));
          in_rd++;
        end
        if (o_wt_rd) begin
          if (!seen_wt_rd) check("wt_first_rd_cyc", cyc, 2);
          seen_wt_rd = 1;
          check("wt_rd_in_range", wt_rd < wt_n, 1);
          check("wt_raddr", o_wt_raddr, 32'((int'(wb) + wt_rd) % 4096));
          wt_rd++;
        end
        if (Input_rdy) begin
          if (!seen_in_rdy) check("in_first_rdy_cyc", cyc, 4);
          seen_in_rdy = 1;
          check("in_rdy_expected", in_x < in_n, 1);
          if (Input_ack) begin
            check("in_data", o_Input_data, in_mem[(int'(ib) + in_x) % 4096]);
            in_x++;
          end
        end
        if (Weight_rdy) begin
          if (!seen_wt_rdy) check("wt_first_rdy_cyc", cyc, 4);
          seen_wt_rdy = 1;
          check("wt_rdy_expected", wt_x < wt_n, 1);
          if (Weight_ack) begin
            check("wt_data", o_Weight_data, wt_mem[(int'(wb) + wt_x) % 4096]);
            wt_x++;
          end
        end
        check("in_occupancy", (in_rd - in_x) <= 2, 1);
        check("wt_occupancy", (wt_rd - wt_x) <= 2, 1);
        p_in_hold = Input_rdy && !Input_ack;
        p_in_data = o_Input_data;
        p_wt_hold = Weight_rdy && !Weight_ack;
        p_wt_data = o_Weight_data;
        if (abort_after >= 0 && abort_cyc < 0 && in_x >= abort_after) abort_cyc = cyc + 1;
        if (done_exp < 0 && in_x == in_n && wt_x == wt_n) done_exp = cyc + 1;
        if (cyc == done_exp) fin = 1'b1;
      end
    end

    check("run_terminated", fin, 1);
    if (abort_after < 0 && rst_cyc < 0) begin
      check("in_reads", in_rd, in_n);
      check("in_xfers", in_x, in_n);
      check("wt_reads", wt_rd, wt_n);
      check("wt_xfers", wt_x, wt_n);
      if (ack_pct == 100 && mx > 0) check("throughput_done_cyc", done_exp, 4 + mx);
    end
    @(negedge clk);
    i_start = 0; i_abort = 0; Input_ack = 0; Weight_ack = 0;
    i_rst_n = 1'b1;
  endtask

  initial begin
    FeedConf basic;
    for (int a = 0; a < 4096; a++) begin
      in_mem[a] = 16'($urandom);
      wt_mem[a] = 16'($urandom);
    end
    i_rst_n = 1'b0; i_start = 0; i_abort = 0; Input_ack = 0; Weight_ack = 0;
    i_conf = '0; i_in_base = '0; i_wt_base = '0;
    repeat (2) @(negedge clk);
    check("reset_in_rd", o_in_rd, 0);
    check("reset_in_raddr", o_in_raddr, 0);
    check("reset_wt_rd", o_wt_rd, 0);
    check("reset_wt_raddr", o_wt_raddr, 0);
    check("reset_in_rdy", Input_rdy, 0);
    check("reset_in_data", o_Input_data, 0);
    check("reset_wt_rdy", Weight_rdy, 0);
    check("reset_wt_data", o_Weight_data, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    i_rst_n = 1'b1;

    basic = mk_conf(2, 3, 2, 2, 0, 0);
    run_cfg(basic, 12'h010, 12'h100, 100, -1, -1, 0);
    run_cfg(mk_conf(1, 3, 1, 4, 1, 1), 12'h200, 12'h300, 100, -1, -1, 0);
    for (int k = 0; k < 6; k++)
      run_cfg(mk_conf($urandom_range(4, 1), $urandom_range(5, 1), $urandom_range(3, 0),
                      $urandom_range(8, 1), $urandom_range(3, 1), 1'($urandom)),
              12'($urandom), 12'($urandom), 50, -1, -1, k[0]);
    run_cfg(mk_conf(2, 3, 0, 2, 0, 0), 12'h040, 12'h080, 100, -1, -1, 0);
    run_cfg(mk_conf(0, 3, 2, 2, 1, 0), 12'h040, 12'h080, 100, -1, -1, 0);
    run_cfg(basic, 12'h010, 12'h100, 100, 5, -1, 0);
    run_cfg(basic, 12'h010, 12'h100, 100, -1, -1, 0);
    run_cfg(basic, 12'h010, 12'h100, 70, -1, 8, 0);
    run_cfg(basic, 12'h010, 12'h100, 70, -1, -1, 0);
    run_cfg(basic, 12'h010, 12'h100, 100, -1, -1, 1);
    run_cfg(mk_conf(1, 2, 1, 2, 0, 0), 12'hFFE, 12'hFFF, 100, -1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
# pe_stream_feeder

Producer end of the PE `Input` and `Weight` rdy/ack streams. The PE datapath controller acknowledges these streams one word per transfer. On `i_start`, this block fetches the exact number of input-pixel words and weight words the PE controller will ack for one configuration. It reads them from the global buffer (GLB) over two fixed-latency read ports and presents them in PE consumption order, with backpressure-safe 2-entry prefetch per stream.

## Interface
Parameters:
- `DATAWD`, 16: word width of one input pixel / weight word.
- `ADDRWD`, 12: GLB word-address width.

Ports:
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `i_start`, input, 1: single-cycle pulse; accepted only in IDLE.
- `i_abort`, input, 1: terminates the current configuration, from any state.
- `i_conf`, input, `FeedConf`: Pch[3:0], R[3:0], Pm[3:0], Tw[5:0], U[3:0], PixReuse. Sampled in LOAD.
- `i_in_base`, input, ADDRWD: first GLB address of the input tile.
- `i_wt_base`, input, ADDRWD: first GLB address of the weight tile.
- `o_in_rd`, output, 1: input GLB read strobe.
- `o_in_raddr`, output, ADDRWD: input GLB read address.
- `i_in_rdata`, input, DATAWD: valid exactly 1 cycle after `o_in_rd`.
- `o_wt_rd`, `o_wt_raddr`, `i_wt_rdata`: weight equivalents of the three input GLB ports.
- `Input_rdy`, output, 1: input word available.
- `Input_ack`, input, 1: consumer accepts. Transfer occurs on `rdy && ack`.
- `o_Input_data`, output, DATAWD: input word.
- `Weight_rdy`, `Weight_ack`, `o_Weight_data`: weight equivalents of the input stream ports.
- `o_busy`, output, 1: high in LOAD, RUN and DONE.
- `o_done`, output, 1: one-cycle pulse at normal completion.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE goes to LOAD on `i_start`.
  - LOAD always lasts one cycle. It latches `i_conf` and both bases, and computes the stream counts.
  - LOAD goes to RUN if either count is nonzero, else to DONE.
  - RUN goes to DONE when both channels have issued all reads, have 0 outstanding reads, and have empty FIFOs.
  - DONE goes to IDLE after one cycle.
- `i_start` outside IDLE is ignored.
- `i_abort` has priority in every state. The next state is IDLE; FIFOs and counters are cleared; a read returning in the following cycle is discarded; `o_done` is not pulsed.
- Row tile width:
  - `row_tile = PixReuse ? Tw*U + R - 1 : Tw*R`.
  - Computed at 10 bits.
  - Configurations where `row_tile > 255` are illegal and are not checked.
- Stream counts, both 16-bit unsigned:
  - Input count = Pch*row_tile.
  - Weight count = Pch*R*Pm.
  - Any zero factor gives count 0 for that stream. That stream then never asserts rdy.
- Addresses are linear, incrementing by 1 per issued read:
  - Input: `i_in_base` up to `i_in_base + count - 1`.
  - Weight: `i_wt_base` up to `i_wt_base + count - 1`.
  - The address wraps modulo 2^ADDRWD.
- Stream order is Pch fastest. The GLB layout already matches this, so the feeder only walks addresses linearly.
- Each channel runs independently with a credit rule:
  - The channel issues a read in a RUN cycle when `remaining > 0` and `fifo_count + outstanding - pop < 2`.
  - `pop` = transfer in the same cycle.
- Returned data is written into the 2-entry FIFO. `rdy` = FIFO non-empty; `data` = FIFO head.
- Simultaneous push and pop in the same cycle is allowed.
- The FIFO never overflows; the credit rule guarantees this.

## Timing
- Reset values: all outputs 0, FSM in IDLE, FIFOs empty.
- Start sequence, with `i_start` in cycle 0:
  - LOAD in cycle 1.
  - First `o_in_rd`/`o_wt_rd` in cycle 2.
  - rdata in cycle 3, written at the end of cycle 3.
  - `Input_rdy` first high in cycle 4.
- With ack held high, each stream sustains 1 word/cycle.
- Once `rdy` is high, it and `data` stay stable until the transfer.
- `rdy` never depends combinationally on `ack`.
- `o_done` is high in the cycle after the final transfer. This requires no outstanding reads and both FIFOs empty.
- The Pch=0 (both counts 0) case: `o_done` in cycle 2, with no GLB reads.

## Structure
- `FeedConf` typedef belongs in `PECtlCfg`, next to the PE control typedefs.
- The rdy/ack macros come from the shared include.
- One sub-module, `pe_feed_chan`, is instantiated twice (input and weight). It contains:
  - remaining-count and address counter,
  - outstanding flag,
  - credit logic,
  - 2-entry FIFO.
- The FSM and count arithmetic stay in the top module.

## Test plan
- **Basic stream:**
  - Stimulus: Pch=2, R=3, Tw=2, PixReuse=0, Pm=2, bases 0x010/0x100, both acks tied 1.
  - Response: 12 input words from addresses 0x010–0x01B and 12 weight words from 0x100–0x10B, transferred in cycles 4–15. `o_done` high in cycle 16.
- **Pixel reuse:**
  - Stimulus: Pch=1, Tw=4, U=1, R=3, PixReuse=1, Pm=1.
  - Response: exactly 6 input words and 3 weight words, in address order.
- **Random backpressure:**
  - Stimulus: acks low 50% of cycles.
  - Response: data/rdy stable while un-acked, never more than 2 words buffered plus outstanding, order preserved, done after the last transfer.
- **Zero counts:**
  - Stimulus: Pm=0.
  - Response: `Weight_rdy` never rises and the input stream completes normally.
  - Stimulus: Pch=0.
  - Response: `o_done` in cycle 2 with no reads.
- **Abort and reset mid-run:**
  - Stimulus: `i_abort` after 5 transfers.
  - Response: IDLE next cycle, both rdy low, no `o_done`. A fresh start streams again from the base address.
  - Stimulus: `i_rst_n` low mid-run.
  - Response: same end state, asynchronously.
- **Start ignored and address wrap:**
  - Stimulus: `i_start` pulsed during RUN.
  - Response: no effect.
  - Stimulus: `i_in_base` = 0xFFE with count 4.
  - Response: addresses 0xFFE, 0xFFF, 0x000, 0x001.
